// File: rtl/seq_pattern_detector_pkg.sv
// Shared definitions for the serial pattern detector: overlap mode selectors
// and the sizing rule for the fill counter.
package seq_det_pkg;

  localparam bit OVERLAP_ON  = 1'b1;
  localparam bit OVERLAP_OFF = 1'b0;

  // The fill counter must be able to represent 0..w inclusive.
  function automatic int unsigned fill_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_pattern_detector_if.sv
// Stream, configuration and status signals of the pattern detector.
interface seq_pattern_detector_if #(
  parameter int unsigned PATTERN_W = 2,
  parameter int unsigned CNT_W     = 8
);

  logic                 din_valid;
  logic                 din;
  logic                 cfg_load;
  logic [PATTERN_W-1:0] cfg_pattern;
  logic                 cnt_clr;
  logic                 match;
  logic [CNT_W-1:0]     match_count;
  logic [PATTERN_W-1:0] pattern;

  modport master (
    output din_valid, din, cfg_load, cfg_pattern, cnt_clr,
    input  match, match_count, pattern
  );

  modport slave (
    input  din_valid, din, cfg_load, cfg_pattern, cnt_clr,
    output match, match_count, pattern
  );

endinterface

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating event counter; a clear coinciding with an increment yields 1
// so the concurrent event is not lost.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? W'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with a runtime-loadable pattern, selectable
// overlapping/non-overlapping detection and a saturating match counter.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned          PATTERN_W   = 2,
  parameter logic [PATTERN_W-1:0] PATTERN_RST = 2'b01,
  parameter bit                   OVERLAP     = OVERLAP_ON,
  parameter int unsigned          CNT_W       = 8
) (
  input logic                  clk,
  input logic                  rst,
  seq_pattern_detector_if.slave bus
);

  localparam int unsigned FILL_W = fill_width(PATTERN_W);

  logic [PATTERN_W-1:0] history;
  logic [PATTERN_W-1:0] window;
  logic [PATTERN_W-1:0] pattern;
  logic [FILL_W-1:0]    fill;
  logic                 fill_ok;
  logic                 hit;
  logic                 match;
  logic [CNT_W-1:0]     match_count;

  // Window is the history as it would look once din is shifted in.
  if (PATTERN_W == 1) begin : g_window_1
    assign window = bus.din;
  end else begin : g_window_n
    assign window = {history[PATTERN_W-2:0], bus.din};
  end

  assign fill_ok = (fill >= FILL_W'(PATTERN_W - 1));
  assign hit     = bus.din_valid & ~bus.cfg_load & fill_ok & (window == pattern);

  always_ff @(posedge clk) begin
    if (rst) begin
      history <= '0;
      fill    <= '0;
      pattern <= PATTERN_RST;
      match   <= 1'b0;
    end else begin
      match <= hit;
      if (bus.cfg_load) begin
        pattern <= bus.cfg_pattern;
        history <= '0;
        fill    <= '0;
      end else if (bus.din_valid) begin
        if (hit && (OVERLAP == OVERLAP_OFF)) begin
          history <= '0;
          fill    <= '0;
        end else begin
          history <= window;
          if (fill != FILL_W'(PATTERN_W)) begin
            fill <= fill + 1'b1;
          end
        end
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit),
    .clr   (bus.cnt_clr),
    .count (match_count)
  );

  assign bus.match       = match;
  assign bus.match_count = match_count;
  assign bus.pattern     = pattern;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Drives three detector variants (2-bit overlap, 3-bit overlap, 3-bit
// non-overlap) with a shared stream and compares them to a queue-based model.
module tb_seq_pattern_detector;

  typedef bit bitq_t[$];

  logic clk;
  logic rst;

  int unsigned total;
  int unsigned bad;

  seq_pattern_detector_if #(.PATTERN_W(2), .CNT_W(4)) ifa ();
  seq_pattern_detector_if #(.PATTERN_W(3), .CNT_W(4)) ifb ();
  seq_pattern_detector_if #(.PATTERN_W(3), .CNT_W(4)) ifc ();

  seq_pattern_detector #(
    .PATTERN_W(2), .PATTERN_RST(2'b01), .OVERLAP(1'b1), .CNT_W(4)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  seq_pattern_detector #(
    .PATTERN_W(3), .PATTERN_RST(3'b101), .OVERLAP(1'b1), .CNT_W(4)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  seq_pattern_detector #(
    .PATTERN_W(3), .PATTERN_RST(3'b101), .OVERLAP(1'b0), .CNT_W(4)
  ) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the bits seen since the last flush, per instance.
  bitq_t       q_a, q_b, q_c;
  logic [31:0] pat_m   [3];
  int unsigned cnt_m   [3];
  bit          match_m [3];
  logic [1:0]  cfg_a;
  logic [2:0]  cfg_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // The last w bits (oldest first) must equal pat, MSB first.
  function automatic bit hit_of(input bitq_t q, input int unsigned w,
                                input logic [31:0] pat, input bit d);
    bit b;
    if (q.size() + 1 < w) return 1'b0;
    for (int unsigned i = 0; i < w; i++) begin
      b = (i == w - 1) ? d : q[q.size() - (w - 1) + i];
      if (b != pat[w-1-i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bitq_t next_q(input bitq_t q, input bit r, input bit v,
                                   input bit ld, input bit h, input bit ov, input bit d);
    bitq_t e;
    if (r || ld) return e;
    if (!v) return q;
    if (h && !ov) return e;
    q.push_back(d);
    if (q.size() > 8) void'(q.pop_front());
    return q;
  endfunction

  task automatic tick(input bit r, input bit v, input bit d, input bit ld, input bit clr);
    bit h [3];
    rst = r;
    ifa.din_valid = v; ifb.din_valid = v; ifc.din_valid = v;
    ifa.din = d;       ifb.din = d;       ifc.din = d;
    ifa.cfg_load = ld; ifb.cfg_load = ld; ifc.cfg_load = ld;
    ifa.cnt_clr = clr; ifb.cnt_clr = clr; ifc.cnt_clr = clr;
    ifa.cfg_pattern = cfg_a; ifb.cfg_pattern = cfg_b; ifc.cfg_pattern = cfg_b;
    h[0] = !r && v && !ld && hit_of(q_a, 2, pat_m[0], d);
    h[1] = !r && v && !ld && hit_of(q_b, 3, pat_m[1], d);
    h[2] = !r && v && !ld && hit_of(q_c, 3, pat_m[2], d);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        cnt_m[k]   = 0;
        match_m[k] = 1'b0;
      end else begin
        match_m[k] = h[k];
        if (clr) cnt_m[k] = h[k] ? 1 : 0;
        else if (h[k] && cnt_m[k] < 15) cnt_m[k]++;
      end
    end
    q_a = next_q(q_a, r, v, ld, h[0], 1'b1, d);
    q_b = next_q(q_b, r, v, ld, h[1], 1'b1, d);
    q_c = next_q(q_c, r, v, ld, h[2], 1'b0, d);
    if (r) begin
      pat_m[0] = 32'h1; pat_m[1] = 32'h5; pat_m[2] = 32'h5;
    end else if (ld) begin
      pat_m[0] = 32'(cfg_a); pat_m[1] = 32'(cfg_b); pat_m[2] = 32'(cfg_b);
    end
    check("a.match",   32'(ifa.match),       32'(match_m[0]));
    check("a.count",   32'(ifa.match_count), cnt_m[0]);
    check("a.pattern", 32'(ifa.pattern),     pat_m[0]);
    check("b.match",   32'(ifb.match),       32'(match_m[1]));
    check("b.count",   32'(ifb.match_count), cnt_m[1]);
    check("b.pattern", 32'(ifb.pattern),     pat_m[1]);
    check("c.match",   32'(ifc.match),       32'(match_m[2]));
    check("c.count",   32'(ifc.match_count), cnt_m[2]);
    check("c.pattern", 32'(ifc.pattern),     pat_m[2]);
  endtask

  task automatic bit_in(input bit d);
    tick(1'b0, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cfg_a = 2'b01;
    cfg_b = 3'b101;
    rst   = 1'b1;
    ifa.din_valid = 1'b0; ifb.din_valid = 1'b0; ifc.din_valid = 1'b0;
    ifa.din = 1'b0;       ifb.din = 1'b0;       ifc.din = 1'b0;
    ifa.cfg_load = 1'b0;  ifb.cfg_load = 1'b0;  ifc.cfg_load = 1'b0;
    ifa.cnt_clr = 1'b0;   ifb.cnt_clr = 1'b0;   ifc.cnt_clr = 1'b0;
    ifa.cfg_pattern = cfg_a; ifb.cfg_pattern = cfg_b; ifc.cfg_pattern = cfg_b;

    // Reset state and the basic 2-bit stream.
    do_reset();
    check("rst.a.count", 32'(ifa.match_count), 32'd0);
    check("rst.a.pattern", 32'(ifa.pattern), 32'h1);
    bit_in(0); bit_in(1);
    check("s1.match2", 32'(ifa.match), 32'd1);
    bit_in(1); bit_in(0); bit_in(1);
    check("s1.match5", 32'(ifa.match), 32'd1);
    check("s1.count", 32'(ifa.match_count), 32'd2);

    // Overlap versus flush on 10101 with pattern 101.
    do_reset();
    bit_in(1); bit_in(0); bit_in(1);
    check("s2.b.match3", 32'(ifb.match), 32'd1);
    check("s2.c.match3", 32'(ifc.match), 32'd1);
    bit_in(0); bit_in(1);
    check("s2.b.count", 32'(ifb.match_count), 32'd2);
    check("s2.c.count", 32'(ifc.match_count), 32'd1);

    // Idle cycles between the 0 and the 1.
    do_reset();
    bit_in(0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("s3.idle", 32'(ifa.match), 32'd0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    bit_in(1);
    check("s3.count", 32'(ifa.match_count), 32'd1);

    // cfg_load discards the concurrent bit and flushes history.
    do_reset();
    bit_in(0);
    cfg_a = 2'b10;
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("s4.load.match", 32'(ifa.match), 32'd0);
    check("s4.load.pattern", 32'(ifa.pattern), 32'h2);
    bit_in(1); bit_in(0);
    check("s4.count", 32'(ifa.match_count), 32'd1);

    // Saturation and clear-with-hit.
    cfg_a = 2'b01;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      bit_in(0); bit_in(1);
    end
    check("s5.sat", 32'(ifa.match_count), 32'd15);
    bit_in(0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("s5.clr_hit", 32'(ifa.match_count), 32'd1);

    // Reset mid-sequence drops the partial history.
    bit_in(0);
    do_reset();
    bit_in(1);
    check("s6.match", 32'(ifa.match), 32'd0);
    check("s6.count", 32'(ifa.match_count), 32'd0);
    check("s6.pattern", 32'(ifa.pattern), 32'h1);

    // Randomized traffic with occasional reloads, clears and resets.
    for (int i = 0; i < 800; i++) begin
      bit r, v, d, ld, clr;
      r   = ($urandom_range(0, 99) == 0);
      v   = ($urandom_range(0, 9) < 7);
      d   = 1'($urandom);
      ld  = ($urandom_range(0, 39) == 0);
      clr = ($urandom_range(0, 24) == 0);
      cfg_a = 2'($urandom);
      cfg_b = 3'($urandom);
      tick(r, v, d, ld, clr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
